// File: rtl/swd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : swd_pkg
// Description : Shared definitions for the SWD transfer path: ACK codes
//               returned by the SWD bit engine and the state encoding of the
//               transfer sequencer (swd_xfer_ctl).
// Revision    : 1.0 - initial release
// ============================================================================
package swd_pkg;

    // ACK codes as presented by the bit engine (LSB first on the wire,
    // already reassembled into this bit order).
    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_BUSY  = 3'd2,
        S_EVAL  = 3'd3,
        S_RESP  = 3'd4
    } xfer_state_e;

endpackage : swd_pkg
`default_nettype wire

// File: rtl/swd_xfer_ctl.sv
`default_nettype none
// ============================================================================
// Module      : swd_xfer_ctl
// Description : Transfer sequencer in front of the SWD bit engine. Accepts
//               one DAP register transfer over valid/ready, drives the
//               engine go/idle handshake, re-issues on WAIT and on
//               value-match mismatches within latched retry limits, and
//               returns a single registered response.
// Ports       :
//   clk, rst                 - clock, synchronous active-high reset
//   req_*                    - request channel (valid/ready)
//   cfg_waitretry/matchretry - retry limits, latched at acceptance
//   cfg_matchmask            - read-data mask for value-match compare
//   abort                    - stop retrying (sticky until next accept)
//   addr32/rnw/apndp/dwrite  - transfer fields to engine
//   go / idle                - engine start request / engine idle
//   ack/dread/perr           - engine result
//   rsp_*                    - response channel (valid/ready)
// Revision    : 1.0 - initial release
// ============================================================================
module swd_xfer_ctl
    import swd_pkg::*;
#(
    parameter int RETRY_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    // request channel
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_addr32,
    input  logic               req_rnw,
    input  logic               req_apndp,
    input  logic [31:0]        req_wdata,
    input  logic               req_match,
    input  logic [31:0]        req_matchval,
    // configuration
    input  logic [RETRY_W-1:0] cfg_waitretry,
    input  logic [RETRY_W-1:0] cfg_matchretry,
    input  logic [31:0]        cfg_matchmask,
    input  logic               abort,
    // bit engine
    output logic [1:0]         addr32,
    output logic               rnw,
    output logic               apndp,
    output logic [31:0]        dwrite,
    output logic               go,
    input  logic               idle,
    input  logic [2:0]         ack,
    input  logic [31:0]        dread,
    input  logic               perr,
    // response channel
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_ack,
    output logic [31:0]        rsp_data,
    output logic               rsp_perr,
    output logic               rsp_mismatch
);

    localparam logic [RETRY_W-1:0] C_CNT_ONE = {{(RETRY_W-1){1'b0}}, 1'b1};

    xfer_state_e        state_q,        state_d;
    logic               req_ready_q,    req_ready_d;
    logic               go_q,           go_d;
    logic [1:0]         addr32_q,       addr32_d;
    logic               rnw_q,          rnw_d;
    logic               apndp_q,        apndp_d;
    logic [31:0]        dwrite_q,       dwrite_d;
    logic               match_q,        match_d;
    logic [31:0]        matchval_q,     matchval_d;
    logic [31:0]        mask_q,         mask_d;
    logic [RETRY_W-1:0] wait_lim_q,     wait_lim_d;
    logic [RETRY_W-1:0] match_lim_q,    match_lim_d;
    logic [RETRY_W-1:0] wait_cnt_q,     wait_cnt_d;
    logic [RETRY_W-1:0] match_cnt_q,    match_cnt_d;
    logic               abort_q,        abort_d;
    logic               rsp_valid_q,    rsp_valid_d;
    logic [2:0]         rsp_ack_q,      rsp_ack_d;
    logic [31:0]        rsp_data_q,     rsp_data_d;
    logic               rsp_perr_q,     rsp_perr_d;
    logic               rsp_mismatch_q, rsp_mismatch_d;

    logic               w_abort_seen;
    logic               w_val_ne;
    logic               w_respond;
    logic               w_resp_mism;

    // An abort arriving in the very cycle of the decision is honoured too.
    assign w_abort_seen = abort_q | abort;
    assign w_val_ne     = ((dread & mask_q) != matchval_q);

    always_comb begin
        state_d        = state_q;
        go_d           = go_q;
        addr32_d       = addr32_q;
        rnw_d          = rnw_q;
        apndp_d        = apndp_q;
        dwrite_d       = dwrite_q;
        match_d        = match_q;
        matchval_d     = matchval_q;
        mask_d         = mask_q;
        wait_lim_d     = wait_lim_q;
        match_lim_d    = match_lim_q;
        wait_cnt_d     = wait_cnt_q;
        match_cnt_d    = match_cnt_q;
        abort_d        = abort_q | (abort && (state_q != S_IDLE));
        rsp_ack_d      = rsp_ack_q;
        rsp_data_d     = rsp_data_q;
        rsp_perr_d     = rsp_perr_q;
        rsp_mismatch_d = rsp_mismatch_q;
        w_respond      = 1'b0;
        w_resp_mism    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // req_ready_q is the registered image of state==S_IDLE and
                // stays low through reset, so it gates acceptance.
                if (req_valid && req_ready_q) begin
                    addr32_d    = req_addr32;
                    rnw_d       = req_rnw;
                    apndp_d     = req_apndp;
                    dwrite_d    = req_wdata;
                    match_d     = req_match & req_rnw;
                    matchval_d  = req_matchval;
                    mask_d      = cfg_matchmask;
                    wait_lim_d  = cfg_waitretry;
                    match_lim_d = cfg_matchretry;
                    wait_cnt_d  = '0;
                    match_cnt_d = '0;
                    abort_d     = 1'b0;
                    go_d        = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Engine has picked up the request once it leaves idle;
                // go must be low before it can return to idle.
                if (!idle) begin
                    go_d    = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (idle) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if ((ack == ACK_WAIT) && (wait_cnt_q < wait_lim_q) && !w_abort_seen) begin
                    wait_cnt_d = wait_cnt_q + C_CNT_ONE;
                    go_d       = 1'b1;
                    state_d    = S_ISSUE;
                end else if (rnw_q && perr) begin
                    w_respond = 1'b1;
                end else if ((ack == ACK_OK) && match_q && w_val_ne) begin
                    if ((match_cnt_q < match_lim_q) && !w_abort_seen) begin
                        match_cnt_d = match_cnt_q + C_CNT_ONE;
                        go_d        = 1'b1;
                        state_d     = S_ISSUE;
                    end else begin
                        w_respond   = 1'b1;
                        w_resp_mism = 1'b1;
                    end
                end else begin
                    w_respond = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                go_d    = 1'b0;
            end
        endcase

        if (w_respond) begin
            rsp_ack_d      = ack;
            rsp_data_d     = (rnw_q && (ack == ACK_OK)) ? dread : 32'd0;
            rsp_perr_d     = rnw_q & perr;
            rsp_mismatch_d = w_resp_mism;
            state_d        = S_RESP;
        end

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            req_ready_q    <= 1'b0;
            go_q           <= 1'b0;
            addr32_q       <= '0;
            rnw_q          <= 1'b0;
            apndp_q        <= 1'b0;
            dwrite_q       <= '0;
            match_q        <= 1'b0;
            matchval_q     <= '0;
            mask_q         <= '0;
            wait_lim_q     <= '0;
            match_lim_q    <= '0;
            wait_cnt_q     <= '0;
            match_cnt_q    <= '0;
            abort_q        <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_ack_q      <= '0;
            rsp_data_q     <= '0;
            rsp_perr_q     <= 1'b0;
            rsp_mismatch_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            go_q           <= go_d;
            addr32_q       <= addr32_d;
            rnw_q          <= rnw_d;
            apndp_q        <= apndp_d;
            dwrite_q       <= dwrite_d;
            match_q        <= match_d;
            matchval_q     <= matchval_d;
            mask_q         <= mask_d;
            wait_lim_q     <= wait_lim_d;
            match_lim_q    <= match_lim_d;
            wait_cnt_q     <= wait_cnt_d;
            match_cnt_q    <= match_cnt_d;
            abort_q        <= abort_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_ack_q      <= rsp_ack_d;
            rsp_data_q     <= rsp_data_d;
            rsp_perr_q     <= rsp_perr_d;
            rsp_mismatch_q <= rsp_mismatch_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign go           = go_q;
    assign addr32       = addr32_q;
    assign rnw          = rnw_q;
    assign apndp        = apndp_q;
    assign dwrite       = dwrite_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_ack      = rsp_ack_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_perr     = rsp_perr_q;
    assign rsp_mismatch = rsp_mismatch_q;

endmodule : swd_xfer_ctl
`default_nettype wire

// File: tb/tb_swd_xfer_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_swd_xfer_ctl
// Description : Directed self-checking bench for swd_xfer_ctl with a small
//               behavioural SWD bit-engine model driven by a per-transfer
//               script of ACK / read data values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_swd_xfer_ctl;

    localparam int RETRY_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_addr32;
    logic               req_rnw;
    logic               req_apndp;
    logic [31:0]        req_wdata;
    logic               req_match;
    logic [31:0]        req_matchval;
    logic [RETRY_W-1:0] cfg_waitretry;
    logic [RETRY_W-1:0] cfg_matchretry;
    logic [31:0]        cfg_matchmask;
    logic               abort;
    logic [1:0]         addr32;
    logic               rnw;
    logic               apndp;
    logic [31:0]        dwrite;
    logic               go;
    logic               idle;
    logic [2:0]         ack;
    logic [31:0]        dread;
    logic               perr;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2:0]         rsp_ack;
    logic [31:0]        rsp_data;
    logic               rsp_perr;
    logic               rsp_mismatch;

    int n_chk = 0;
    int n_err = 0;

    // engine script and capture
    logic [2:0]  ack_seq   [8];
    logic [31:0] dread_seq [8];
    logic        perr_seq;
    int          n_xfer;
    logic [1:0]  cap_addr32;
    logic        cap_rnw;
    logic        cap_apndp;
    logic [31:0] cap_dwrite;

    always #5 clk = ~clk;

    swd_xfer_ctl #(.RETRY_W(RETRY_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr32     (req_addr32),
        .req_rnw        (req_rnw),
        .req_apndp      (req_apndp),
        .req_wdata      (req_wdata),
        .req_match      (req_match),
        .req_matchval   (req_matchval),
        .cfg_waitretry  (cfg_waitretry),
        .cfg_matchretry (cfg_matchretry),
        .cfg_matchmask  (cfg_matchmask),
        .abort          (abort),
        .addr32         (addr32),
        .rnw            (rnw),
        .apndp          (apndp),
        .dwrite         (dwrite),
        .go             (go),
        .idle           (idle),
        .ack            (ack),
        .dread          (dread),
        .perr           (perr),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_ack        (rsp_ack),
        .rsp_data       (rsp_data),
        .rsp_perr       (rsp_perr),
        .rsp_mismatch   (rsp_mismatch)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_script(input logic [2:0] a0, input logic [2:0] a_rest,
                              input logic [31:0] d0, input logic [31:0] d_rest,
                              input logic p);
        ack_seq[0]   = a0;
        dread_seq[0] = d0;
        for (int i = 1; i < 8; i++) begin
            ack_seq[i]   = a_rest;
            dread_seq[i] = d_rest;
        end
        perr_seq = p;
    endtask

    // Behavioural bit engine: starts on go while idle, stays busy a few
    // clocks, then presents the scripted result and returns to idle.
    initial begin
        int k;
        idle  = 1'b1;
        ack   = 3'b000;
        dread = 32'd0;
        perr  = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst && go && idle) begin
                k = (n_xfer < 8) ? n_xfer : 7;
                n_xfer++;
                cap_addr32 = addr32;
                cap_rnw    = rnw;
                cap_apndp  = apndp;
                cap_dwrite = dwrite;
                #1;
                idle = 1'b0;
                ack  = 3'b000;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    if (rst) break;
                    if (c == 1) begin
                        #1;
                        check("go_low_in_busy", go, 0);
                    end
                end
                #1;
                if (!rst) begin
                    ack   = ack_seq[k];
                    dread = dread_seq[k];
                    perr  = perr_seq;
                end
                idle = 1'b1;
            end
        end
    end

    // One complete transfer; results are checked by the caller.
    logic [2:0]  r_ack;
    logic [31:0] r_data;
    logic        r_perr;
    logic        r_mism;

    task automatic run_xfer(input logic [1:0] a, input logic r, input logic ap,
                            input logic [31:0] wd, input logic m, input logic [31:0] mv,
                            input bit do_abort, input int hold);
        int t;
        n_xfer = 0;
        @(negedge clk);
        req_addr32   = a;
        req_rnw      = r;
        req_apndp    = ap;
        req_wdata    = wd;
        req_match    = m;
        req_matchval = mv;
        req_valid    = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("go_after_accept", go, 1);
        // changing the limits now must not affect the accepted transfer
        cfg_waitretry  = '0;
        cfg_matchretry = '0;
        cfg_matchmask  = 32'hFFFF_FFFF;
        if (do_abort) begin
            t = 0;
            while (idle && t < 50) begin
                @(negedge clk);
                t++;
            end
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        t = 0;
        while (!rsp_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        r_ack  = rsp_ack;
        r_data = rsp_data;
        r_perr = rsp_perr;
        r_mism = rsp_mismatch;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_ready_low", req_ready, 0);
            check("hold_fields", {rsp_ack, rsp_data, rsp_perr, rsp_mismatch},
                                 {r_ack, r_data, r_perr, r_mism});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ready_back", req_ready, 1);
        check("valid_dropped", rsp_valid, 0);
    endtask

    initial begin
        int t;
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_addr32     = '0;
        req_rnw        = 1'b0;
        req_apndp      = 1'b0;
        req_wdata      = '0;
        req_match      = 1'b0;
        req_matchval   = '0;
        cfg_waitretry  = '0;
        cfg_matchretry = '0;
        cfg_matchmask  = '0;
        abort          = 1'b0;
        rsp_ready      = 1'b0;
        n_xfer         = 0;
        set_script(3'b001, 3'b001, 32'd0, 32'd0, 1'b0);

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_go", go, 0);
        check("rst_rsp", {rsp_valid, rsp_ack, rsp_data, rsp_perr, rsp_mismatch}, 0);
        check("rst_engine", {addr32, rnw, apndp, dwrite}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", req_ready, 1);

        // OK write: data must read back 0 even though the engine drives dread
        cfg_waitretry = 16'd3;
        set_script(3'b001, 3'b001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        run_xfer(2'd2, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'd0, 0, 0);
        check("wr_xfers", n_xfer, 1);
        check("wr_fields", {cap_addr32, cap_rnw, cap_apndp, cap_dwrite}, {2'd2, 1'b0, 1'b1, 32'h1234_5678});
        check("wr_rsp", {r_ack, r_data, r_perr, r_mism}, {3'b001, 32'd0, 1'b0, 1'b0});

        // read, WAIT twice then OK
        cfg_waitretry = 16'd3;
        set_script(3'b010, 3'b010, 32'd0, 32'd0, 1'b0);
        ack_seq[2]   = 3'b001;
        dread_seq[2] = 32'hCAFE_F00D;
        run_xfer(2'd1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 0, 0);
        check("wait2_xfers", n_xfer, 3);
        check("wait2_rsp", {r_ack, r_data, r_perr, r_mism}, {3'b001, 32'hCAFE_F00D, 1'b0, 1'b0});

        // WAIT forever, limit 2 -> 3 attempts
        cfg_waitretry = 16'd2;
        set_script(3'b010, 3'b010, 32'h1111_1111, 32'h1111_1111, 1'b0);
        run_xfer(2'd0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 0, 0);
        check("waitx_xfers", n_xfer, 3);
        check("waitx_rsp", {r_ack, r_data, r_perr, r_mism}, {3'b010, 32'd0, 1'b0, 1'b0});

        // same with abort during the first transfer
        cfg_waitretry = 16'd2;
        run_xfer(2'd0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 1, 0);
        check("abort_xfers", n_xfer, 1);
        check("abort_rsp", {r_ack, r_data, r_perr, r_mism}, {3'b010, 32'd0, 1'b0, 1'b0});

        // match read: 0x100 mismatches, 0x15A matches under mask 0xFF
        cfg_waitretry  = 16'd0;
        cfg_matchretry = 16'd4;
        cfg_matchmask  = 32'h0000_00FF;
        set_script(3'b001, 3'b001, 32'h0000_0100, 32'h0000_015A, 1'b0);
        run_xfer(2'd3, 1'b1, 1'b1, 32'd0, 1'b1, 32'h0000_005A, 0, 0);
        check("match_xfers", n_xfer, 2);
        check("match_rsp", {r_ack, r_data, r_perr, r_mism}, {3'b001, 32'h0000_015A, 1'b0, 1'b0});

        // match read never matching -> 5 attempts, mismatch flagged
        cfg_matchretry = 16'd4;
        cfg_matchmask  = 32'h0000_00FF;
        set_script(3'b001, 3'b001, 32'd0, 32'd0, 1'b0);
        run_xfer(2'd3, 1'b1, 1'b1, 32'd0, 1'b1, 32'h0000_005A, 0, 0);
        check("mism_xfers", n_xfer, 5);
        check("mism_rsp", {r_ack, r_data, r_perr, r_mism}, {3'b001, 32'd0, 1'b0, 1'b1});

        // parity error on a mismatching match read: no retry, held response
        cfg_matchretry = 16'd4;
        cfg_matchmask  = 32'h0000_00FF;
        set_script(3'b001, 3'b001, 32'h0000_0077, 32'h0000_0077, 1'b1);
        run_xfer(2'd1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_005A, 0, 10);
        check("perr_xfers", n_xfer, 1);
        check("perr_rsp", {r_ack, r_data, r_perr, r_mism}, {3'b001, 32'h0000_0077, 1'b1, 1'b0});

        // FAULT write is never retried even with a WAIT budget
        cfg_waitretry = 16'd5;
        set_script(3'b100, 3'b100, 32'h2222_2222, 32'h2222_2222, 1'b0);
        run_xfer(2'd1, 1'b0, 1'b0, 32'hA5A5_0F0F, 1'b0, 32'd0, 0, 0);
        check("fault_xfers", n_xfer, 1);
        check("fault_rsp", {r_ack, r_data, r_perr, r_mism}, {3'b100, 32'd0, 1'b0, 1'b0});

        // reset while the engine is busy
        set_script(3'b001, 3'b001, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        req_rnw   = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (idle && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rstbusy_engine_busy", idle, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstbusy_go", go, 0);
        check("rstbusy_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstbusy_ready", req_ready, 1);
        repeat (10) @(negedge clk);
        check("rstbusy_quiet", {go, rsp_valid}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule : tb_swd_xfer_ctl
`default_nettype wire
